// File: rtl/a25_cache_flush_ctrl_if.sv
// Flush-controller bundle: request/handshake inputs from core, CP15 and tag RAM,
// plus the tag-clear write port and the status outputs.
interface a25_cache_flush_ctrl_if #(
  parameter int LINE_W = 8,
  parameter int WAYS   = 4
);
  logic              i_flush_req;
  logic              i_disrupt_req;
  logic              i_cache_enable;
  logic              i_core_quiet;
  logic              i_tag_ready;
  logic              o_busy;
  logic              o_stall;
  logic              o_tag_wen;
  logic [LINE_W-1:0] o_tag_addr;
  logic [WAYS-1:0]   o_way_sel;
  logic              o_done;
  logic [15:0]       o_flush_count;

  modport master (
    output i_flush_req, i_disrupt_req, i_cache_enable, i_core_quiet, i_tag_ready,
    input  o_busy, o_stall, o_tag_wen, o_tag_addr, o_way_sel, o_done, o_flush_count
  );

  modport slave (
    input  i_flush_req, i_disrupt_req, i_cache_enable, i_core_quiet, i_tag_ready,
    output o_busy, o_stall, o_tag_wen, o_tag_addr, o_way_sel, o_done, o_flush_count
  );
endinterface

// File: rtl/a25_cache_flush_ctrl.sv
// Amber 25 cache flush sequencer: stalls the core, waits for quiet, then clears
// every tag line across all ways under a ready handshake, coalescing overlapping requests.
module a25_cache_flush_ctrl #(
  parameter int LINES  = 256,
  parameter int LINE_W = 8,
  parameter int WAYS   = 4
) (
  input  logic clk,
  input  logic reset,
  a25_cache_flush_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, DONE} state_t;

  localparam logic [LINE_W-1:0] LAST_IDX = LINE_W'(LINES - 1);

  state_t            state_q;
  logic              pending_q;
  logic [LINE_W-1:0] index_q;
  logic              busy_q;
  logic              tag_wen_q;
  logic [LINE_W-1:0] tag_addr_q;
  logic [WAYS-1:0]   way_sel_q;
  logic              done_q;
  logic [15:0]       count_q;
  logic              trig;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // A disruptive-region hit only matters when the cache is actually on.
  assign trig = bus.i_flush_req | (bus.i_disrupt_req & bus.i_cache_enable);

  // Outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      index_q    <= '0;
      busy_q     <= 1'b0;
      tag_wen_q  <= 1'b0;
      tag_addr_q <= '0;
      way_sel_q  <= '0;
      done_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      tag_wen_q  <= 1'b0;
      tag_addr_q <= '0;
      way_sel_q  <= '0;
      done_q     <= 1'b0;
      if (trig && (state_q == DRAIN || state_q == CLEAR)) pending_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (trig) begin
            state_q <= DRAIN;
            busy_q  <= 1'b1;
          end
        end
        DRAIN: begin
          if (bus.i_core_quiet) begin
            state_q    <= CLEAR;
            index_q    <= '0;
            tag_wen_q  <= 1'b1;
            tag_addr_q <= '0;
            way_sel_q  <= '1;
          end
        end
        CLEAR: begin
          if (bus.i_tag_ready && index_q == LAST_IDX) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            count_q <= sat_inc16(count_q);
          end else if (bus.i_tag_ready) begin
            index_q    <= index_q + 1'b1;
            tag_wen_q  <= 1'b1;
            tag_addr_q <= index_q + 1'b1;
            way_sel_q  <= '1;
          end else begin
            tag_wen_q  <= 1'b1;
            tag_addr_q <= index_q;
            way_sel_q  <= '1;
          end
        end
        DONE: begin
          // A trigger landing in this cycle folds into the restart too.
          if (pending_q || trig) begin
            state_q   <= DRAIN;
            pending_q <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy        = busy_q;
  assign bus.o_stall       = busy_q;
  assign bus.o_tag_wen     = tag_wen_q;
  assign bus.o_tag_addr    = tag_addr_q;
  assign bus.o_way_sel     = way_sel_q;
  assign bus.o_done        = done_q;
  assign bus.o_flush_count = count_q;

endmodule
